// File: rtl/mda_vram_arbiter.sv
// mda_vram_arbiter: shares the MDA cell RAM between fixed-latency video fetch and a FIFO'd host write port.
// Define MDA_VRAM_CLEAR_EN to sweep 16'h0720 into every cell after reset before host writes drain.
module mda_vram_arbiter #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 16,
   parameter int CELLS      = 2000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   input  logic              host_valid,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              drop_err,
   output logic              clear_busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(CELLS);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS-1);
   localparam logic [DATA_W-1:0] CLR_WORD = DATA_W'(16'h0720);
   typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] count, count_nx;
   logic [ADDR_W-1:0] head_addr, clr_addr;
   logic [DATA_W-1:0] head_data;
   logic push, g_clr, g_fifo, vid_in, head_in, wr_hit;
   logic v1, v2, r1, r2;
   assign head_addr = fifo_addr[rd_ptr];
   assign head_data = fifo_data[rd_ptr];
   assign vid_in = {1'b0, vid_addr} < LIM;
   assign head_in = {1'b0, head_addr} < LIM;
`ifdef MDA_VRAM_CLEAR_EN
   assign clear_busy = state == S_CLEAR;
   assign g_clr = !vid_req && clear_busy;
   assign state_nx = state == S_RESET ? S_CLEAR : (g_clr && clr_addr == LAST) ? S_RUN : state;
   always_ff @(posedge clock or posedge reset)
      if (reset)
         clr_addr <= '0;
      else if (g_clr)
         clr_addr <= clr_addr + 1'b1;
`else
   assign clear_busy = 1'b0;
   assign g_clr = 1'b0;
   assign clr_addr = '0;
   assign state_nx = state == S_RESET ? S_RUN : state;
`endif
   // Video wins every edge it asks for; the FIFO only drains once the sweep is done.
   always_comb begin
      push = host_valid && host_ready;
      g_fifo = !vid_req && state == S_RUN && count != '0;
      wr_hit = g_clr || (g_fifo && head_in);
      count_nx = count + (PW+1)'(push) - (PW+1)'(g_fifo);
   end
   always_ff @(posedge clock)
      if (push) begin
         fifo_addr[wr_ptr] <= host_addr;
         fifo_data[wr_ptr] <= host_data;
      end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state      <= S_RESET;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         host_ready <= 1'b0;
         drop_err   <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         v1         <= 1'b0;
         v2         <= 1'b0;
         r1         <= 1'b0;
         r2         <= 1'b0;
         vid_rvalid <= 1'b0;
         vid_rdata  <= '0;
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         host_ready <= count_nx != FULL;
         wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr     <= g_fifo ? rd_ptr + 1'b1 : rd_ptr;
         drop_err   <= drop_err || (g_fifo && !head_in);
         ram_en     <= vid_req ? vid_in : wr_hit;
         ram_we     <= wr_hit;
         ram_addr   <= vid_req ? vid_addr : g_clr ? clr_addr : g_fifo ? head_addr : ram_addr;
         ram_wdata  <= vid_req ? ram_wdata : g_clr ? CLR_WORD : g_fifo ? head_data : ram_wdata;
         v1         <= vid_req;
         r1         <= vid_in;
         v2         <= v1;
         r2         <= r1;
         vid_rvalid <= v2;
         vid_rdata  <= v2 ? (r2 ? ram_rdata : '0) : vid_rdata;
      end
endmodule

// File: doc/mda_vram_arbiter.md
# mda_vram_arbiter

Shares one single-port character/attribute RAM between the MDA scan-out fetch and a host write port. Sits between `mda_core`'s character fetch logic and the video RAM. Video fetches have absolute priority and fixed latency. Host writes go through a small FIFO and drain into idle RAM cycles.

## Interface
- `ADDR_W`, 11: cell address width.
- `DATA_W`, 16: cell width, `{attr[7:0], char[7:0]}`.
- `CELLS`, 2000: valid cells (80x25). Addresses `>= CELLS` are out of range.
- `FIFO_DEPTH`, 4: host write FIFO depth; power of 2, at least 2.

Ports:
- `clock`  in  1  pixel clock.
- `reset`  in  1  async, active-high reset.
- `vid_req`  in  1  video read request; single-cycle pulse.
- `vid_addr`  in  ADDR_W  video read address, sampled with `vid_req`.
- `vid_rvalid`  out  1  read data valid pulse.
- `vid_rdata`  out  DATA_W  read data.
- `host_valid`  in  1  host write offer.
- `host_addr`  in  ADDR_W  host write address.
- `host_data`  in  DATA_W  host write data.
- `host_ready`  out  1  FIFO can accept a write.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid 1 cycle after an `ram_en` read.
- `drop_err`  out  1  sticky: an out-of-range host write was discarded.
- `clear_busy`  out  1  power-on clear sweep in progress.

## Operation
- Host transfer:
  - A host write is accepted on an edge where `host_valid && host_ready`.
  - `host_ready = !fifo_full`, taken from the registered count.
  - Accepted entries keep their order.
- Slot arbitration, decided on each edge. Priority order:
  1. `vid_req`
  2. clear sweep, when in state CLEAR
  3. FIFO head, when FIFO is not empty
  4. idle
- Granted video read:
  - The RAM read is issued with `vid_addr`.
  - An out-of-range `vid_addr` issues no RAM access; it returns `vid_rdata = 0` with the normal latency.
- Granted FIFO head:
  - The head is popped.
  - If its address is out of range, there is no RAM access and `drop_err` is set.
- Same-edge behaviour:
  - Push and pop on the same edge leave the count unchanged.
  - When the FIFO is full, a pop on an edge frees the slot, but `host_ready` only rises on the following cycle.
- A host write to the address currently being read by video: the read returns the old data, because the video slot wins that edge.
- State machine:
  - RESET → CLEAR if `MDA_VRAM_CLEAR_EN` is defined, otherwise RESET → RUN.
  - CLEAR → RUN after cell `CELLS-1` has been written.
  - RUN is terminal until the next reset.
- `drop_err` clears only on `reset`.
- Reset:
  - Reset asserted mid-operation empties the FIFO, restarts the clear sweep from 0, and discards any in-flight `vid_rvalid`.
  - Reset values: `vid_rvalid=0`, `vid_rdata=0`, `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `host_ready=0`, `drop_err=0`, `clear_busy=0`.
  - `host_ready` rises 1 cycle after reset deasserts.

## Timing
- RAM outputs (`ram_en`, `ram_we`, `ram_addr`, `ram_wdata`) are registered: a slot granted on edge t drives the RAM during cycle t..t+1.
- Video read latency:
  - `vid_req` is sampled on edge t.
  - `ram_en` is high after t.
  - `ram_rdata` is registered at t+1.
  - `vid_rvalid`/`vid_rdata` are high for exactly one cycle after edge t+2.
  - Total: 2 cycles, fixed, including for out-of-range addresses.
- Host write: earliest RAM write is 1 cycle after acceptance (push on edge t, pop on edge t+1). The RAM write then follows the same registered timing.
- Throughput: one RAM access per cycle. MDA fetches one cell per 9 clocks, which leaves at least 8 cycles in 9 for writes during active video.
- The host stalls only on FIFO full. Back-to-back `vid_req` on every cycle starves the FIFO indefinitely. This is legal; the host sees `host_ready=0`.

## Configuration
- `MDA_VRAM_CLEAR_EN` defined:
  - After reset the block is in CLEAR with `clear_busy=1`.
  - It writes `16'h0720` (space, normal attribute) to addresses `0..CELLS-1`, ascending, one per free slot.
  - Video reads preempt the sweep; the sweep pauses and does not skip a cell.
  - The FIFO accepts writes during CLEAR but does not drain until RUN, so host writes land after the clear.
  - `clear_busy` falls on the edge that issues the write to `CELLS-1`.
- `MDA_VRAM_CLEAR_EN` undefined: the block goes straight to RUN, `clear_busy` is tied to 0, and no sweep logic is present.

## Test plan
- Video read latency:
  - Stimulus: preload RAM `[5]=16'h0741`, pulse `vid_req` with `vid_addr=5` on edge t.
  - Required response: exactly one `vid_rvalid` after edge t+2, with `vid_rdata=16'h0741`.
- Contention:
  - Stimulus: `host_valid` held with `addr=10`, `data=16'h0F42`, while `vid_req` is pulsed every cycle for 6 cycles.
  - Required response: no RAM write during the burst; after the burst, `ram_we` with `addr=10`, `data=16'h0F42`; video data is uncorrupted.
- FIFO full:
  - Stimulus: with `FIFO_DEPTH=4`, hold `vid_req` high and offer 6 writes.
  - Required response: 4 writes accepted, then `host_ready=0`. After `vid_req` drops, the 4 writes drain in order, 1 per cycle.
- Out of range:
  - Stimulus: host write to `addr=2000`.
  - Required response: no `ram_en`, `drop_err=1` and sticky. A `vid_req` at `addr=2047` returns `vid_rdata=0` after 2 cycles.
- Clear sweep (`MDA_VRAM_CLEAR_EN` defined):
  - Stimulus: reset, with one `vid_req` every 9 cycles.
  - Required response: all 2000 cells read back `16'h0720`; `clear_busy` falls after 2000 writes.
- Reset mid-operation:
  - Stimulus: assert `reset` with 3 FIFO entries and a read in flight.
  - Required response: no `vid_rvalid` and no RAM writes after reset; FIFO empty; the sweep restarts at address 0.
